ysyx_25040111_mem_arbiter: RTL and testbench

YSYX_25040111_MEM_ARBITER -- requirements
Module: ysyx_25040111_mem_arbiter

---
 rtl/ysyx_25040111_mem_arbiter_pkg.sv | 21 ++
 rtl/ysyx_25040111_mem_arbiter_rr2.sv | 26 ++
 rtl/ysyx_25040111_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_ysyx_25040111_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared encodings for the icache/LSU memory arbiter: one-hot FSM states,
// grant owner identifiers and access size codes.
package ysyx_25040111_mem_arbiter_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    IC_RD = 4'b0010,
    LS_RD = 4'b0100,
    LS_WR = 4'b1000
  } state_t;

  typedef enum logic {
    GRANT_IC = 1'b0,
    GRANT_LS = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_rr2.sv
// Two-requester tie-break: a lone requester always wins; on a tie the requester
// not granted last wins (RR_EN=1) or the LSU wins outright (RR_EN=0).
module ysyx_25040111_rr2
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic   req_ic,
  input  logic   req_ls,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  always_comb begin
    grant_valid = req_ic | req_ls;
    grant       = GRANT_IC;
    if (req_ic && req_ls) begin
      if (RR_EN && (last_grant == GRANT_LS)) grant = GRANT_IC;
      else                                   grant = GRANT_LS;
    end else if (req_ls) begin
      grant = GRANT_LS;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Arbitrates icache burst reads and LSU loads/stores onto one downstream
// read/write port; the winner's payload is latched at the grant edge.
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_valid,
  output logic        ic_ready,
  input  logic [31:0] ic_addr,
  input  logic [7:0]  ic_len,
  input  logic        ic_burst,
  output logic [31:0] ic_data,
  output logic        ic_dvalid,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [1:0]  ls_mask,
  input  logic        ls_rsign,
  output logic [31:0] ls_rdata,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic [31:0] m_raddr,
  output logic [7:0]  m_rlen,
  output logic        m_burst,
  output logic        m_rsign,
  output logic [1:0]  m_rmask,
  input  logic [31:0] m_rdata,
  input  logic        m_rbeat,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_wmask
);

  state_t      state, next_state;
  grant_t      last_grant, grant;
  logic        grant_valid;
  logic        done;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  len_q;
  logic        burst_q, rsign_q;
  logic [1:0]  mask_q;
  logic        rvalid_q, wvalid_q;

  ysyx_25040111_rr2 #(.RR_EN(RR_EN)) u_rr2 (
    .req_ic      (ic_valid),
    .req_ls      (ls_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Only the completion input belonging to the current state can end a transaction.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          if (grant == GRANT_IC) next_state = IC_RD;
          else if (ls_write)     next_state = LS_WR;
          else                   next_state = LS_RD;
        end
      end
      IC_RD, LS_RD: done = m_rready;
      LS_WR:        done = m_wready;
      default:      next_state = IDLE;
    endcase
    if (done) next_state = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_IC;
      rvalid_q   <= 1'b0;
      wvalid_q   <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      len_q      <= 8'h0;
      burst_q    <= 1'b0;
      rsign_q    <= 1'b0;
      mask_q     <= 2'b00;
    end else begin
      state <= next_state;
      if ((state == IDLE) && grant_valid) begin
        last_grant <= grant;
        if (grant == GRANT_IC) begin
          addr_q   <= ic_addr;
          len_q    <= ic_len;
          burst_q  <= ic_burst;
          mask_q   <= SIZE_WORD;
          rsign_q  <= 1'b0;
          rvalid_q <= 1'b1;
        end else begin
          addr_q   <= ls_addr;
          wdata_q  <= ls_wdata;
          len_q    <= 8'h0;
          burst_q  <= 1'b0;
          mask_q   <= ls_mask;
          rsign_q  <= ls_rsign;
          rvalid_q <= ~ls_write;
          wvalid_q <= ls_write;
        end
      end else if (done) begin
        rvalid_q <= 1'b0;
        wvalid_q <= 1'b0;
      end
      if ((state == LS_RD) && m_rready) rdata_q <= m_rdata;
    end
  end

  // Ready pulses are suppressed under reset so an abandoned transaction never completes.
  assign ic_ready  = (state == IC_RD) & m_rready & ~reset;
  assign ls_ready  = (((state == LS_RD) & m_rready) | ((state == LS_WR) & m_wready)) & ~reset;
  assign ic_dvalid = (state == IC_RD) & m_rbeat;
  assign ic_data   = (state == IC_RD) ? m_rdata : 32'h0;
  assign ls_rdata  = ((state == LS_RD) && m_rready) ? m_rdata : rdata_q;

  assign m_rvalid = rvalid_q;
  assign m_raddr  = addr_q;
  assign m_rlen   = len_q;
  assign m_burst  = burst_q;
  assign m_rsign  = rsign_q;
  assign m_rmask  = mask_q;
  assign m_wvalid = wvalid_q;
  assign m_waddr  = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wmask  = mask_q;

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: directed requests push expected
// downstream transactions; a negedge monitor pops and checks them.
module tb_ysyx_25040111_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        ic_valid, ic_burst, ls_valid, ls_write, ls_rsign;
  logic [31:0] ic_addr, ls_addr, ls_wdata;
  logic [7:0]  ic_len;
  logic [1:0]  ls_mask;
  logic        m_rready, m_rbeat, m_wready;
  logic [31:0] m_rdata;

  logic        ic_ready, ic_dvalid, ls_ready, m_rvalid, m_burst, m_rsign, m_wvalid;
  logic [31:0] ic_data, ls_rdata, m_raddr, m_waddr, m_wdata;
  logic [7:0]  m_rlen;
  logic [1:0]  m_rmask, m_wmask;

  logic        ic_valid_f, ls_valid_f, m_rready_f, m_wready_f;
  logic        ic_ready_f, ic_dvalid_f, ls_ready_f, m_rvalid_f, m_burst_f, m_rsign_f, m_wvalid_f;
  logic [31:0] ic_data_f, ls_rdata_f, m_raddr_f, m_waddr_f, m_wdata_f;
  logic [7:0]  m_rlen_f;
  logic [1:0]  m_rmask_f, m_wmask_f;

  ysyx_25040111_mem_arbiter #(.RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ic_valid(ic_valid), .ic_ready(ic_ready), .ic_addr(ic_addr), .ic_len(ic_len),
    .ic_burst(ic_burst), .ic_data(ic_data), .ic_dvalid(ic_dvalid),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_mask(ls_mask), .ls_rsign(ls_rsign), .ls_rdata(ls_rdata),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_raddr(m_raddr), .m_rlen(m_rlen),
    .m_burst(m_burst), .m_rsign(m_rsign), .m_rmask(m_rmask), .m_rdata(m_rdata),
    .m_rbeat(m_rbeat), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wmask(m_wmask)
  );

  ysyx_25040111_mem_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clock(clock), .reset(reset),
    .ic_valid(ic_valid_f), .ic_ready(ic_ready_f), .ic_addr(ic_addr), .ic_len(ic_len),
    .ic_burst(ic_burst), .ic_data(ic_data_f), .ic_dvalid(ic_dvalid_f),
    .ls_valid(ls_valid_f), .ls_ready(ls_ready_f), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_mask(ls_mask), .ls_rsign(ls_rsign), .ls_rdata(ls_rdata_f),
    .m_rvalid(m_rvalid_f), .m_rready(m_rready_f), .m_raddr(m_raddr_f), .m_rlen(m_rlen_f),
    .m_burst(m_burst_f), .m_rsign(m_rsign_f), .m_rmask(m_rmask_f), .m_rdata(m_rdata),
    .m_rbeat(m_rbeat), .m_wvalid(m_wvalid_f), .m_wready(m_wready_f), .m_waddr(m_waddr_f),
    .m_wdata(m_wdata_f), .m_wmask(m_wmask_f)
  );

  typedef struct packed {
    logic        is_ic;
    logic        is_write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        burst;
    logic [1:0]  mask;
    logic        rsign;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic busy = 1'b0;
  int   beats = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void check_output(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endfunction

  function automatic void push_exp(input logic is_ic, input logic is_write, input logic [31:0] addr,
                                   input logic [7:0] len, input logic burst, input logic [1:0] mask,
                                   input logic rsign, input logic [31:0] wdata, input logic [31:0] data);
    exp_t e;
    e.is_ic = is_ic; e.is_write = is_write; e.addr = addr; e.len = len; e.burst = burst;
    e.mask = mask; e.rsign = rsign; e.wdata = wdata; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: a new downstream request pops the next expected transaction; beats and ready pulses are checked against it.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        busy  = 1'b0;
        beats = 0;
      end else begin
        if (!busy && (m_rvalid || m_wvalid)) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_request", 32'({m_rvalid, m_wvalid}), 32'd0);
          end else begin
            cur   = exp_q.pop_front();
            busy  = 1'b1;
            beats = 0;
            check_output("req_wvalid", 32'(m_wvalid), 32'(cur.is_write));
            check_output("req_rvalid", 32'(m_rvalid), 32'(!cur.is_write));
            if (cur.is_write) begin
              check_output("m_waddr", m_waddr, cur.addr);
              check_output("m_wdata", m_wdata, cur.wdata);
              check_output("m_wmask", 32'(m_wmask), 32'(cur.mask));
            end else begin
              check_output("m_raddr", m_raddr, cur.addr);
              check_output("m_rlen", 32'(m_rlen), 32'(cur.len));
              check_output("m_burst", 32'(m_burst), 32'(cur.burst));
              check_output("m_rmask", 32'(m_rmask), 32'(cur.mask));
              check_output("m_rsign", 32'(m_rsign), 32'(cur.rsign));
            end
          end
        end
        if (ic_dvalid) begin
          if (busy && cur.is_ic) begin
            check_output("ic_data", ic_data, cur.data + 32'(beats));
            beats++;
          end else begin
            check_output("stray_ic_dvalid", 32'(ic_dvalid), 32'd0);
          end
        end
        if (ic_ready || ls_ready) begin
          if (!busy) begin
            check_output("stray_ready", 32'({ic_ready, ls_ready}), 32'd0);
          end else begin
            check_output("ready_owner_ic", 32'(ic_ready), 32'(cur.is_ic));
            check_output("ready_owner_ls", 32'(ls_ready), 32'(!cur.is_ic));
            if (cur.is_ic) check_output("ic_beat_count", 32'(beats), 32'(cur.len) + 32'd1);
            else if (!cur.is_write) check_output("ls_rdata", ls_rdata, cur.data);
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic write, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (write ? m_wvalid : m_rvalid) begin
        ok = 1'b1;
        return;
      end
    end
    check_output(name, 32'd0, 32'd1);
  endtask

  task automatic serve_read(input string name, input int n, input logic [31:0] base);
    logic ok;
    wait_valid(name, 1'b0, ok);
    if (!ok) return;
    step();
    for (int k = 0; k < n; k++) begin
      m_rbeat  = 1'b1;
      m_rdata  = base + 32'(k);
      m_rready = (k == n - 1);
      step();
    end
    m_rbeat  = 1'b0;
    m_rready = 1'b0;
    m_rdata  = 32'h0;
  endtask

  task automatic apply_stimulus();
    logic ok;

    // Reset state
    reset = 1'b1;
    ic_valid = 0; ic_burst = 0; ic_addr = 0; ic_len = 0;
    ls_valid = 0; ls_write = 0; ls_addr = 0; ls_wdata = 0; ls_mask = 0; ls_rsign = 0;
    m_rready = 0; m_rbeat = 0; m_wready = 0; m_rdata = 0;
    ic_valid_f = 0; ls_valid_f = 0; m_rready_f = 0; m_wready_f = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("rst_m_rvalid", 32'(m_rvalid), 32'd0);
    check_output("rst_m_wvalid", 32'(m_wvalid), 32'd0);
    check_output("rst_readies", 32'({ic_ready, ls_ready, ic_dvalid}), 32'd0);
    check_output("rst_m_raddr", m_raddr, 32'd0);
    check_output("rst_ls_rdata", ls_rdata, 32'd0);
    step();
    reset = 1'b0;

    // Icache 8-beat incrementing burst
    push_exp(1, 0, 32'h3000_0000, 8'd7, 1, 2'b10, 0, 32'h0, 32'hA000_0000);
    ic_addr = 32'h3000_0000; ic_len = 8'd7; ic_burst = 1'b1; ic_valid = 1'b1;
    @(negedge clock);
    check_output("ic_grant_cycle_rvalid", 32'(m_rvalid), 32'd0);
    @(negedge clock);
    check_output("ic_rvalid_t_plus_1", 32'(m_rvalid), 32'd1);
    ic_addr = 32'h0;
    serve_read("ic_burst_timeout", 8, 32'hA000_0000);
    ic_valid = 1'b0;
    @(negedge clock);
    check_output("ic_idle_after", 32'({m_rvalid, ic_ready}), 32'd0);

    // Simultaneous requests after reset: LSU first, icache in the following IDLE cycle
    do_reset();
    push_exp(0, 0, 32'h8000_0010, 8'd0, 0, 2'b10, 0, 32'h0, 32'h1234_5678);
    push_exp(1, 0, 32'h3000_0040, 8'd1, 1, 2'b10, 0, 32'h0, 32'hC000_0000);
    ic_addr = 32'h3000_0040; ic_len = 8'd1; ic_burst = 1'b1; ic_valid = 1'b1;
    ls_addr = 32'h8000_0010; ls_mask = 2'b10; ls_rsign = 1'b0; ls_write = 1'b0; ls_valid = 1'b1;
    serve_read("tie_ls_timeout", 1, 32'h1234_5678);
    ls_valid = 1'b0;
    @(negedge clock);
    check_output("tie_idle_gap", 32'(m_rvalid), 32'd0);
    check_output("ls_rdata_held", ls_rdata, 32'h1234_5678);
    @(negedge clock);
    check_output("tie_ic_granted", 32'(m_rvalid), 32'd1);
    serve_read("tie_ic_timeout", 2, 32'hC000_0000);
    ic_valid = 1'b0;
    step();

    // Store with late m_wready; requester drops valid and payload mid-transaction
    push_exp(0, 1, 32'h8000_0004, 8'd0, 0, 2'b01, 0, 32'hDEAD_BEEF, 32'h0);
    ls_addr = 32'h8000_0004; ls_wdata = 32'hDEAD_BEEF; ls_mask = 2'b01; ls_write = 1'b1; ls_valid = 1'b1;
    wait_valid("store_timeout", 1'b1, ok);
    step();
    ls_valid = 1'b0; ls_wdata = 32'h0; ls_addr = 32'h0; ls_mask = 2'b00; ls_write = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_output("store_wdata_stable", m_wdata, 32'hDEAD_BEEF);
      check_output("store_wmask_stable", 32'(m_wmask), 32'd1);
      check_output("store_no_rvalid", 32'(m_rvalid), 32'd0);
      step();
    end
    m_wready = 1'b1;
    @(negedge clock);
    check_output("store_ls_ready", 32'(ls_ready), 32'd1);
    step();
    m_wready = 1'b0;
    @(negedge clock);
    check_output("store_ready_one_cycle", 32'({ls_ready, m_wvalid}), 32'd0);

    // Reset during the third beat of an icache burst
    push_exp(1, 0, 32'h3000_0100, 8'd3, 1, 2'b10, 0, 32'h0, 32'hB000_0000);
    ic_addr = 32'h3000_0100; ic_len = 8'd3; ic_burst = 1'b1; ic_valid = 1'b1;
    wait_valid("rstmid_timeout", 1'b0, ok);
    step();
    for (int k = 0; k < 2; k++) begin
      m_rbeat = 1'b1; m_rdata = 32'hB000_0000 + 32'(k);
      step();
    end
    m_rdata = 32'hB000_0002; reset = 1'b1;
    @(negedge clock);
    check_output("rstmid_no_ic_ready", 32'(ic_ready), 32'd0);
    step();
    reset = 1'b0; m_rbeat = 1'b0; m_rdata = 32'h0; ic_valid = 1'b0;
    @(negedge clock);
    check_output("rstmid_valids", 32'({m_rvalid, m_wvalid, ic_ready, ls_ready, ic_dvalid}), 32'd0);
    check_output("rstmid_payload", m_raddr | 32'(m_rlen) | 32'(m_burst) | 32'(m_rmask), 32'd0);
    check_output("rstmid_data", ic_data | ls_rdata, 32'd0);
    step();
    push_exp(0, 0, 32'h8000_0020, 8'd0, 0, 2'b00, 1, 32'h0, 32'h0000_00FF);
    ls_addr = 32'h8000_0020; ls_mask = 2'b00; ls_rsign = 1'b1; ls_write = 1'b0; ls_valid = 1'b1;
    serve_read("post_rst_timeout", 1, 32'h0000_00FF);
    ls_valid = 1'b0; ls_rsign = 1'b0;
    step();

    // Stray completions: m_wready in IC_RD, m_rready/m_wready in IDLE
    push_exp(1, 0, 32'h3000_0080, 8'd0, 0, 2'b10, 0, 32'h0, 32'hD000_0000);
    ic_addr = 32'h3000_0080; ic_len = 8'd0; ic_burst = 1'b0; ic_valid = 1'b1;
    wait_valid("stray_timeout", 1'b0, ok);
    step();
    m_wready = 1'b1;
    step();
    @(negedge clock);
    check_output("stray_wready_rvalid", 32'(m_rvalid), 32'd1);
    check_output("stray_wready_readies", 32'({ic_ready, ls_ready, m_wvalid}), 32'd0);
    step();
    m_wready = 1'b0;
    m_rbeat = 1'b1; m_rdata = 32'hD000_0000; m_rready = 1'b1;
    step();
    m_rbeat = 1'b0; m_rdata = 32'h0; ic_valid = 1'b0;
    m_wready = 1'b1;
    @(negedge clock);
    check_output("stray_idle_valids", 32'({m_rvalid, m_wvalid}), 32'd0);
    check_output("stray_idle_readies", 32'({ic_ready, ls_ready}), 32'd0);
    step();
    m_rready = 1'b0; m_wready = 1'b0;
    step();

    // Fixed priority instance: LSU wins every round while both are held
    ic_addr = 32'h3000_0200; ic_len = 8'd0; ic_burst = 1'b0;
    ls_addr = 32'h8000_0030; ls_mask = 2'b10; ls_write = 1'b0;
    ic_valid_f = 1'b1; ls_valid_f = 1'b1;
    for (int r = 0; r < 3; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 32 && !ok; i++) begin
        @(negedge clock);
        ok = m_rvalid_f;
      end
      check_output($sformatf("fixed_grant_seen_r%0d", r), 32'(ok), 32'd1);
      check_output($sformatf("fixed_grant_addr_r%0d", r), m_raddr_f, 32'h8000_0030);
      step();
      m_rready_f = 1'b1;
      @(negedge clock);
      check_output($sformatf("fixed_owner_r%0d", r), 32'({ic_ready_f, ls_ready_f}), 32'd1);
      step();
      m_rready_f = 1'b0;
    end
    ic_valid_f = 1'b0; ls_valid_f = 1'b0;
    step();
  endtask

  initial begin
    apply_stimulus();
    @(negedge clock);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check_output("monitor_idle", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
